// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: memcontrol codes, FSM states
// and requester ownership.
package mem_arb_pkg;

    localparam logic [1:0] MC_IDLE  = 2'b00;
    localparam logic [1:0] MC_READ  = 2'b01;
    localparam logic [1:0] MC_WRITE = 2'b10;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } arb_state_t;

    function automatic logic [1:0] mc_encode(input logic we);
        return we ? MC_WRITE : MC_READ;
    endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin pick between fetch and data requesters; on a tie the
// requester that did not win last time is chosen.
module mem_arb_rr2
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
    input  logic last_gnt,
    output logic winner,
    output logic gnt_valid
);

    // winner selection from request levels and the previous owner
    always_comb begin
        winner    = OWN_IF;
        gnt_valid = 1'b0;
        if (if_req && dm_req) begin
            gnt_valid = 1'b1;
            winner    = (last_gnt == OWN_IF) ? OWN_DM : OWN_IF;
        end else if (if_req) begin
            gnt_valid = 1'b1;
            winner    = OWN_IF;
        end else if (dm_req) begin
            gnt_valid = 1'b1;
            winner    = OWN_DM;
        end else begin
            gnt_valid = 1'b0;
            winner    = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and data accesses,
// holding each access for MEM_LAT cycles and returning read data with a valid pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [1:0]        memcontrol,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dataout,
    input  logic [DATA_W-1:0] datain,
    output logic              busy
);

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

    arb_state_t state_r;
    logic       owner_r;
    logic       we_r;
    logic       last_gnt_r;
    logic [2:0] cnt_r;
    logic       win_s;
    logic       win_valid_s;

    mem_arb_rr2 u_rr2 (
        .if_req    (if_req),
        .dm_req    (dm_req),
        .last_gnt  (last_gnt_r),
        .winner    (win_s),
        .gnt_valid (win_valid_s)
    );

    // access sequencer: arbitration, latch of the winning request, latency count
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r    <= IDLE;
            owner_r    <= OWN_IF;
            we_r       <= 1'b0;
            last_gnt_r <= OWN_DM;
            cnt_r      <= 3'd0;
            if_gnt     <= 1'b0;
            dm_gnt     <= 1'b0;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            memcontrol <= MC_IDLE;
            addr       <= '0;
            dataout    <= '0;
            busy       <= 1'b0;
        end else begin
            if_gnt   <= 1'b0;
            dm_gnt   <= 1'b0;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (win_valid_s) begin
                        owner_r    <= win_s;
                        we_r       <= (win_s == OWN_DM) && dm_we;
                        memcontrol <= mc_encode((win_s == OWN_DM) && dm_we);
                        addr       <= (win_s == OWN_DM) ? dm_addr : if_addr;
                        if (win_s == OWN_DM) begin
                            dataout <= dm_wdata;
                        end else begin
                            dataout <= dataout;
                        end
                        if_gnt  <= (win_s == OWN_IF);
                        dm_gnt  <= (win_s == OWN_DM);
                        cnt_r   <= LAT_LOAD;
                        busy    <= 1'b1;
                        state_r <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (cnt_r == 3'd0) begin
                        // read data is sampled on the final edge of the access window
                        if (!we_r && owner_r == OWN_IF) begin
                            if_rdata <= datain;
                        end else if (!we_r) begin
                            dm_rdata <= datain;
                        end else begin
                            dm_rdata <= dm_rdata;
                        end
                        memcontrol <= MC_IDLE;
                        if_valid   <= (owner_r == OWN_IF);
                        dm_valid   <= (owner_r == OWN_DM);
                        state_r    <= DONE;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                DONE: begin
                    last_gnt_r <= owner_r;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    memcontrol <= MC_IDLE;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule
